// File: rtl/product_accumulator.sv
// Purpose : saturating signed accumulator of 32-bit products over a framed stream; emits total, beat count, overflow per frame.
// Latency : result valid one cycle after the last beat is accepted; 1 beat/cycle in a frame plus one bubble per frame.
// Backpr. : in_ready is low while a result is held; the result stays stable until out_ready, clear drops it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous frame abort (highest priority)
//   in_valid/in_ready   input handshake; in_product (signed 32b), in_last marks final beat
//   out_valid/out_ready output handshake; out_sum (ACC_W), out_count (CNT_W, saturating), out_overflow (sticky)
module product_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             ovf_upd;

    // Gating with rst_n keeps in_ready low while reset is held, even though
    // the state register already sits in ACCUM.
    assign in_ready  = rst_n && (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready && !clear;

    // One extra bit of headroom: the sum of an ACC_W-bit value and a sign-extended
    // 32-bit value never wraps in ACC_W+1 bits, so the top two bits differing
    // means the result is out of the ACC_W-bit range. The MSB gives the direction.
    always_comb begin
        sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-32){in_product[31]}}, in_product};
        acc_upd  = sum_wide[ACC_W-1:0];
        ovf_upd  = ovf;
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_upd = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
            ovf_upd = 1'b1;
        end
        cnt_upd = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && in_last) state_nxt = HOLD;
                HOLD:    if (out_ready)         state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                // Result includes the last beat; the accumulator restarts for the next frame.
                out_sum      <= acc_upd;
                out_count    <= cnt_upd;
                out_overflow <= ovf_upd;
                acc          <= '0;
                cnt          <= '0;
                ovf          <= 1'b0;
            end else begin
                acc <= acc_upd;
                cnt <= cnt_upd;
                ovf <= ovf_upd;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int ACC_W = 34;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_product = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level arithmetic) ----------------
    typedef struct {
        longint sum;
        longint cnt;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    longint m_sum = 0;
    longint m_cnt = 0;
    bit     m_ovf = 0;
    localparam longint SMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (ACC_W-1));
    localparam longint CMAX = (longint'(1) <<< CNT_W) - 1;

    function automatic void model_reset();
        m_sum = 0;
        m_cnt = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_beat(input logic [31:0] p, input bit last);
        exp_t e;
        m_sum = m_sum + longint'($signed(p));
        if (m_sum > SMAX) begin m_sum = SMAX; m_ovf = 1; end
        if (m_sum < SMIN) begin m_sum = SMIN; m_ovf = 1; end
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (last) begin
            e.sum = m_sum; e.cnt = m_cnt; e.ovf = m_ovf;
            q.push_back(e);
            model_reset();
        end
    endfunction

    // ---------------- output-ready driver ----------------
    int rdy_mode = 0; // 0: always ready, 1: random, 2: held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) == 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit               prev_hold = 0;
    logic [ACC_W-1:0] prev_sum;
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            chk("in_ready_vs_out_valid", longint'(in_ready), longint'(!out_valid));
            if (out_valid) begin
                if (prev_hold) begin
                    chk("hold_sum_stable", longint'($signed(out_sum)), longint'($signed(prev_sum)));
                    chk("hold_count_stable", longint'(out_count), longint'(prev_cnt));
                    chk("hold_ovf_stable", longint'(out_overflow), longint'(prev_ovf));
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("out_sum", longint'($signed(out_sum)), e.sum);
                        chk("out_count", longint'(out_count), e.cnt);
                        chk("out_overflow", longint'(out_overflow), longint'(e.ovf));
                    end
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    prev_sum  = out_sum;
                    prev_cnt  = out_count;
                    prev_ovf  = out_overflow;
                end
            end else begin
                prev_hold = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Presents one beat (or a clear cycle) and waits, bounded, for it to be taken.
    task automatic send(input logic [31:0] p, input bit last, input bit clr);
        bit ok;
        bit was_hold;
        int n;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        clear      = clr;
        n = 0;
        do begin
            @(negedge clk);
            ok       = in_ready && !clear;
            was_hold = out_valid;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && !clr && n < 200);
        in_valid = 1'b0;
        clear    = 1'b0;
        if (clr) begin
            if (was_hold && q.size() > 0) void'(q.pop_front());
            model_reset();
            chk("clear_out_valid_low", longint'(out_valid), 0);
            chk("clear_in_ready_high", longint'(in_ready), 1);
        end else if (!ok) begin
            chk("accept_timeout", 1, 0);
        end else begin
            model_beat(p, last);
            if (last) chk("last_latency_out_valid", longint'(out_valid), 1);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        idle(1);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_sum", longint'(out_sum), 0);
        chk("rst_out_count", longint'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // basic frame
        send(32'd100, 0, 0);
        send(-32'sd30, 0, 0);
        send(32'd7, 1, 0);
        idle(2);

        // output backpressure: result held for several cycles
        set_mode(2);
        send(32'd100, 0, 0);
        send(-32'sd30, 0, 0);
        send(32'd7, 1, 0);
        idle(4);
        set_mode(0);
        idle(2);

        // positive saturation, then a fresh frame proves state was cleared
        repeat (5) send(32'h7FFF_FFFF, 0, 0);
        send(32'h7FFF_FFFF, 1, 0);
        send(-32'sd2, 1, 0);
        // negative saturation
        repeat (4) send(32'h8000_0000, 0, 0);
        send(32'h8000_0000, 1, 0);
        // count saturation
        repeat (299) send(32'd1, 0, 0);
        send(32'd1, 1, 0);
        idle(2);

        // clear mid-frame with a beat offered in the same cycle
        send(32'd5, 0, 0);
        send(32'd5, 0, 0);
        send(32'd9, 0, 1);
        send(32'd4, 1, 0);
        idle(2);

        // clear while a result is held drops it
        set_mode(2);
        send(32'd1, 0, 0);
        send(32'd2, 1, 0);
        idle(2);
        send(32'd9, 0, 1);
        set_mode(0);

        // asynchronous reset mid-frame
        send(32'd3, 0, 0);
        send(32'd4, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", longint'(in_ready), 0);
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_sum", longint'(out_sum), 0);
        chk("arst_out_count", longint'(out_count), 0);
        chk("arst_out_overflow", longint'(out_overflow), 0);
        model_reset();
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_release_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        send(32'd3, 1, 0);
        idle(2);

        // randomized frames with random output backpressure and input gaps
        set_mode(1);
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) begin
                logic [31:0] p;
                case ($urandom_range(0, 3))
                    0:       p = 32'h7000_0000 | ($urandom & 32'h0FFF_FFFF);
                    1:       p = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
                    2:       p = $urandom;
                    default: p = 32'($urandom_range(0, 200)) - 32'd100;
                endcase
                send(p, b == len - 1, 0);
                if ($urandom_range(0, 4) == 0) idle(1);
            end
        end

        // drain
        set_mode(0);
        for (int n = 0; n < 100 && q.size() != 0; n++) idle(1);
        idle(2);
        chk("queue_drained", longint'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
